// File: rtl/cache_bus_arbiter.sv
// rtl/cache_bus_arbiter.sv - round-robin cache line arbiter onto one AXI4 master, with snoop invalidation
module cache_bus_arbiter #(
  parameter int NUM_CLIENTS = 2,
  parameter int ADDR_WIDTH  = 64,
  parameter int DATA_WIDTH  = 64,
  parameter int BEATS       = 8,
  parameter int ID_WIDTH    = 13
) (
  input  logic                                    clk,
  input  logic                                    reset,
  input  logic [NUM_CLIENTS-1:0]                  req_valid,
  input  logic [NUM_CLIENTS-1:0]                  req_store,
  input  logic [NUM_CLIENTS*ADDR_WIDTH-1:0]       req_addr,
  input  logic [NUM_CLIENTS*BEATS*DATA_WIDTH-1:0] req_wdata,
  output logic [NUM_CLIENTS-1:0]                  resp_valid,
  output logic [BEATS*DATA_WIDTH-1:0]             resp_data,
  output logic                                    resp_err,
  output logic [ID_WIDTH-1:0]                     m_axi_arid,
  output logic [ADDR_WIDTH-1:0]                   m_axi_araddr,
  output logic [7:0]                              m_axi_arlen,
  output logic [2:0]                              m_axi_arsize,
  output logic [1:0]                              m_axi_arburst,
  output logic                                    m_axi_arlock,
  output logic [3:0]                              m_axi_arcache,
  output logic [2:0]                              m_axi_arprot,
  output logic                                    m_axi_arvalid,
  input  logic                                    m_axi_arready,
  input  logic [DATA_WIDTH-1:0]                   m_axi_rdata,
  input  logic [1:0]                              m_axi_rresp,
  input  logic                                    m_axi_rlast,
  input  logic                                    m_axi_rvalid,
  output logic                                    m_axi_rready,
  output logic [ID_WIDTH-1:0]                     m_axi_awid,
  output logic [ADDR_WIDTH-1:0]                   m_axi_awaddr,
  output logic [7:0]                              m_axi_awlen,
  output logic [2:0]                              m_axi_awsize,
  output logic [1:0]                              m_axi_awburst,
  output logic                                    m_axi_awlock,
  output logic [3:0]                              m_axi_awcache,
  output logic [2:0]                              m_axi_awprot,
  output logic                                    m_axi_awvalid,
  input  logic                                    m_axi_awready,
  output logic [DATA_WIDTH-1:0]                   m_axi_wdata,
  output logic [DATA_WIDTH/8-1:0]                 m_axi_wstrb,
  output logic                                    m_axi_wlast,
  output logic                                    m_axi_wvalid,
  input  logic                                    m_axi_wready,
  input  logic [1:0]                              m_axi_bresp,
  input  logic                                    m_axi_bvalid,
  output logic                                    m_axi_bready,
  input  logic                                    m_axi_acvalid,
  input  logic [ADDR_WIDTH-1:0]                   m_axi_acaddr,
  output logic                                    m_axi_acready,
  output logic                                    inv_valid,
  output logic [ADDR_WIDTH-1:0]                   inv_addr
);
  localparam int LINE = BEATS * DATA_WIDTH;
  localparam int CW   = (NUM_CLIENTS > 1) ? $clog2(NUM_CLIENTS) : 1;
  localparam int BW   = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int OFF  = $clog2(LINE / 8);
  localparam logic [ADDR_WIDTH-1:0] LINE_MASK = ~((ADDR_WIDTH'(1) << OFF) - ADDR_WIDTH'(1));

  typedef enum logic [2:0] {IDLE, RD_ADDR, RD_DATA, WR_ADDR, WR_DATA, WR_RESP, DONE} state_t;

  state_t                  state, state_next;
  logic [CW-1:0]           last_grant, grant_idx, sel_idx, cand;
  logic                    sel_found;
  int                      rr_pos;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [LINE-1:0]         wline_q;
  logic [BW-1:0]           beat;
  logic                    last_beat;

  assign last_beat = (beat == BW'(BEATS - 1));

  // Scan clients starting just after the last one granted.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    rr_pos    = 0;
    cand      = '0;
    for (int i = 0; i < NUM_CLIENTS; i++) begin
      rr_pos = int'(last_grant) + 1 + i;
      if (rr_pos >= NUM_CLIENTS) rr_pos = rr_pos - NUM_CLIENTS;
      cand = CW'(rr_pos);
      if (!sel_found && req_valid[cand]) begin
        sel_found = 1'b1;
        sel_idx   = cand;
      end
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (sel_found) state_next = req_store[sel_idx] ? WR_ADDR : RD_ADDR;
      RD_ADDR: if (m_axi_arready) state_next = RD_DATA;
      RD_DATA: if (m_axi_rvalid && last_beat) state_next = DONE;
      WR_ADDR: if (m_axi_awready) state_next = WR_DATA;
      WR_DATA: if (m_axi_wready && last_beat) state_next = WR_RESP;
      WR_RESP: if (m_axi_bvalid) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    resp_valid = '0;
    if (state == DONE) resp_valid[grant_idx] = 1'b1;
  end

  assign m_axi_arid    = '0;
  assign m_axi_araddr  = addr_q;
  assign m_axi_arlen   = 8'(BEATS - 1);
  assign m_axi_arsize  = 3'($clog2(DATA_WIDTH / 8));
  assign m_axi_arburst = 2'b01;
  assign m_axi_arlock  = 1'b0;
  assign m_axi_arcache = 4'b0;
  assign m_axi_arprot  = 3'b0;
  assign m_axi_arvalid = (state == RD_ADDR);
  assign m_axi_rready  = (state == RD_DATA);
  assign m_axi_awid    = '0;
  assign m_axi_awaddr  = addr_q;
  assign m_axi_awlen   = 8'(BEATS - 1);
  assign m_axi_awsize  = 3'($clog2(DATA_WIDTH / 8));
  assign m_axi_awburst = 2'b01;
  assign m_axi_awlock  = 1'b0;
  assign m_axi_awcache = 4'b0;
  assign m_axi_awprot  = 3'b0;
  assign m_axi_awvalid = (state == WR_ADDR);
  assign m_axi_wdata   = wline_q[beat*DATA_WIDTH +: DATA_WIDTH];
  assign m_axi_wstrb   = '1;
  assign m_axi_wlast   = last_beat;
  assign m_axi_wvalid  = (state == WR_DATA);
  assign m_axi_bready  = (state == WR_RESP);
  assign m_axi_acready = !reset;

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      last_grant <= CW'(NUM_CLIENTS - 1);
      grant_idx  <= '0;
      addr_q     <= '0;
      wline_q    <= '0;
      beat       <= '0;
      resp_data  <= '0;
      resp_err   <= 1'b0;
      inv_valid  <= 1'b0;
      inv_addr   <= '0;
    end else begin
      state     <= state_next;
      inv_valid <= m_axi_acvalid;
      inv_addr  <= m_axi_acaddr & LINE_MASK;
      case (state)
        IDLE: if (sel_found) begin
          grant_idx  <= sel_idx;
          last_grant <= sel_idx;
          addr_q     <= req_addr[sel_idx*ADDR_WIDTH +: ADDR_WIDTH] & LINE_MASK;
          wline_q    <= req_wdata[sel_idx*LINE +: LINE];
          beat       <= '0;
          resp_err   <= 1'b0;
        end
        RD_DATA: if (m_axi_rvalid) begin
          resp_data[beat*DATA_WIDTH +: DATA_WIDTH] <= m_axi_rdata;
          beat <= last_beat ? '0 : beat + BW'(1);
          // rlast is only cross-checked; the local beat count decides the end of the burst.
          if (m_axi_rresp != 2'b00 || m_axi_rlast != last_beat) resp_err <= 1'b1;
        end
        WR_DATA: if (m_axi_wready) beat <= last_beat ? '0 : beat + BW'(1);
        WR_RESP: if (m_axi_bvalid && m_axi_bresp != 2'b00) resp_err <= 1'b1;
        default: ;
      endcase
      // A snoop hitting the line being filled makes the returned data stale.
      if (m_axi_acvalid && (state == RD_ADDR || state == RD_DATA) &&
          (m_axi_acaddr & LINE_MASK) == addr_q)
        resp_err <= 1'b1;
    end
  end
endmodule
